convol_data_feeder: RTL and testbench

- Upstream stage of the one-dimensional convolution kernel.
- Accepts a framed sample stream on a valid/ready handshake and drives the kernel's input_data, enable and coeff inputs.
- Holds a double-buffered coefficient bank. A committed set is swapped in only between frames.
- After each frame's last sample, appends NUM_TAPS-1 zero samples so the kernel pipeline drains.

---
 rtl/convol_data_feeder.sv | 146 ++++++++++++++
 tb/tb_convol_data_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/convol_data_feeder.sv
// convol_data_feeder
//   Upstream stage of the 1-D convolution kernel. Accepts a framed sample
//   stream (valid/ready), forwards each sample to the kernel with one cycle
//   of latency, and appends NUM_TAPS-1 zero samples after every frame so the
//   kernel pipeline drains. Coefficients are double-buffered: writes land in
//   a shadow bank, and a commit swaps shadow->active only while idle between
//   frames, which costs one stall cycle.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   s_data/s_valid/s_last/s_ready   upstream sample stream
//   coeff_wr_en/addr/data           shadow coefficient write port
//   coeff_commit                    request shadow->active swap
//   input_data/enable               sample stream to the kernel
//   coeff                           active bank, tap k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   busy                            frame in progress (STREAM or FLUSH)
//   frame_done                      1-cycle pulse at end of flush
//
// Optional macro CONVOL_FEEDER_STATS_EN adds frame_count and last_frame_len.

module convol_data_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_TAPS    = 8,
    parameter int ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    input  logic                            coeff_wr_en,
    input  logic [ADDR_WIDTH-1:0]           coeff_wr_addr,
    input  logic [COEFF_WIDTH-1:0]          coeff_wr_data,
    input  logic                            coeff_commit,
    output logic [DATA_WIDTH-1:0]           input_data,
    output logic                            enable,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
    output logic                            busy,
`ifdef CONVOL_FEEDER_STATS_EN
    output logic [15:0]                     frame_count,
    output logic [15:0]                     last_frame_len,
`endif
    output logic                            frame_done
);

    localparam int CNT_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                                 state;
    logic                                   commit_pending;
    logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0]   shadow;
    logic [CNT_W-1:0]                       flush_cnt;

    logic accept, swap, last_flush, addr_ok;

    // The swap cycle is the only IDLE cycle that refuses samples; that keeps
    // coeff stable from a frame's first sample through its flush.
    assign s_ready    = !reset && ((state == IDLE && !commit_pending) || state == STREAM);
    assign accept     = s_valid && s_ready;
    assign swap       = (state == IDLE) && commit_pending;
    assign last_flush = (flush_cnt == CNT_W'(NUM_TAPS - 2));
    assign addr_ok    = int'(coeff_wr_addr) < NUM_TAPS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            input_data     <= '0;
            enable         <= 1'b0;
            coeff          <= '0;
            shadow         <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            commit_pending <= 1'b0;
            flush_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;

            if (coeff_wr_en && addr_ok)
                shadow[coeff_wr_addr] <= coeff_wr_data;

            // A commit arriving while one is already pending (including on the
            // swap edge itself) folds into that swap.
            if (swap) begin
                coeff          <= shadow;
                commit_pending <= 1'b0;
            end else if (coeff_commit) begin
                commit_pending <= 1'b1;
            end

            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        input_data <= s_data;
                        enable     <= 1'b1;
                        busy       <= 1'b1;
                        flush_cnt  <= '0;
                        state      <= s_last ? FLUSH : STREAM;
                    end else begin
                        enable <= 1'b0;
                    end
                end
                FLUSH: begin
                    input_data <= '0;
                    enable     <= 1'b1;
                    if (last_flush) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONVOL_FEEDER_STATS_EN
    logic [15:0] len_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_cnt        <= '0;
            frame_count    <= '0;
            last_frame_len <= '0;
        end else begin
            // First accept of a frame happens in IDLE and restarts the count.
            if (accept)
                len_cnt <= (state == IDLE) ? 16'd1 :
                           (len_cnt == 16'hFFFF) ? len_cnt : len_cnt + 16'd1;
            if (state == FLUSH && last_flush) begin
                frame_count    <= frame_count + 16'd1;
                last_frame_len <= len_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_convol_data_feeder.sv
module tb_convol_data_feeder;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 8;
    localparam int AW = 3;
    localparam int NT_B = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DW-1:0]     s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              coeff_wr_en = 1'b0;
    logic [AW-1:0]     coeff_wr_addr = '0;
    logic [CW-1:0]     coeff_wr_data = '0;
    logic              coeff_commit = 1'b0;
    logic [DW-1:0]     input_data;
    logic              enable;
    logic [NT*CW-1:0]  coeff;
    logic              busy;
    logic              frame_done;

    // second instance with a non-power-of-two tap count for address range checks
    logic              b_wr_en = 1'b0;
    logic [2:0]        b_wr_addr = '0;
    logic [CW-1:0]     b_wr_data = '0;
    logic              b_commit = 1'b0;
    logic              b_ready, b_enable, b_busy, b_done;
    logic [DW-1:0]     b_data;
    logic [NT_B*CW-1:0] b_coeff;

`ifdef CONVOL_FEEDER_STATS_EN
    logic [15:0] frame_count, last_frame_len, b_fc, b_lfl;
`endif

    int checks = 0;
    int errors = 0;

    convol_data_feeder #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr),
        .coeff_wr_data(coeff_wr_data), .coeff_commit(coeff_commit),
        .input_data(input_data), .enable(enable), .coeff(coeff), .busy(busy),
`ifdef CONVOL_FEEDER_STATS_EN
        .frame_count(frame_count), .last_frame_len(last_frame_len),
`endif
        .frame_done(frame_done)
    );

    convol_data_feeder #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT_B)) dut_b (
        .clk(clk), .reset(reset),
        .s_data('0), .s_valid(1'b0), .s_last(1'b0), .s_ready(b_ready),
        .coeff_wr_en(b_wr_en), .coeff_wr_addr(b_wr_addr),
        .coeff_wr_data(b_wr_data), .coeff_commit(b_commit),
        .input_data(b_data), .enable(b_enable), .coeff(b_coeff), .busy(b_busy),
`ifdef CONVOL_FEEDER_STATS_EN
        .frame_count(b_fc), .last_frame_len(b_lfl),
`endif
        .frame_done(b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one sample, expect it accepted and forwarded on the next edge
    task automatic send(input logic [DW-1:0] d, input logic last);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        chk("s_ready_stream", s_ready, 1'b1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("enable_data", enable, 1'b1);
        chk("input_data", input_data, d);
        chk("busy_stream", busy, 1'b1);
        chk("no_done_stream", frame_done, 1'b0);
    endtask

    // walk NT-1 flush cycles; frame_done must coincide with the last zero
    task automatic flush(input logic [NT*CW-1:0] exp_coeff);
        for (int j = 0; j < NT - 1; j++) begin
            chk("s_ready_flush", s_ready, 1'b0);
            step();
            chk("enable_flush", enable, 1'b1);
            chk("data_flush", input_data, '0);
            chk("frame_done", frame_done, (j == NT - 2));
            chk("busy_flush", busy, (j != NT - 2));
            chk("coeff_frame", coeff, exp_coeff);
        end
        step();
        chk("enable_idle", enable, 1'b0);
        chk("done_pulse", frame_done, 1'b0);
    endtask

    logic [NT*CW-1:0] c_a, c_b;

    initial begin
        for (int k = 0; k < NT; k++) c_a[k*CW +: CW] = CW'(k + 1);
        c_b = c_a;
        c_b[3*CW +: CW] = 16'hFFFF;

        // reset state
        #2 reset = 1'b1;
        step();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_enable", enable, 1'b0);
        chk("rst_coeff", coeff, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_data", input_data, '0);
        reset = 1'b0;
        #1 chk("idle_ready", s_ready, 1'b1);

        // load taps 1..8, commit in IDLE
        for (int k = 0; k < NT; k++) begin
            coeff_wr_en   = 1'b1;
            coeff_wr_addr = AW'(k);
            coeff_wr_data = CW'(k + 1);
            step();
        end
        coeff_wr_en  = 1'b0;
        chk("coeff_no_direct_write", coeff, '0);
        coeff_commit = 1'b1;
        step();
        coeff_commit = 1'b0;
        chk("stall_ready", s_ready, 1'b0);
        chk("coeff_before_swap", coeff, '0);
        s_valid = 1'b1; s_data = 16'h0055; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("stall_no_accept", enable, 1'b0);
        chk("stall_no_busy", busy, 1'b0);
        chk("coeff_swap", coeff, c_a);
        chk("ready_after_swap", s_ready, 1'b1);

        // 5-sample frame
        for (int i = 0; i < 5; i++) send(DW'(10 * (i + 1)), i == 4);
        flush(c_a);
`ifdef CONVOL_FEEDER_STATS_EN
        chk("frame_count_1", frame_count, 16'd1);
        chk("frame_len_5", last_frame_len, 16'd5);
`endif

        // single-sample frame
        send(16'h7FFF, 1'b1);
        flush(c_a);
`ifdef CONVOL_FEEDER_STATS_EN
        chk("frame_count_2", frame_count, 16'd2);
        chk("frame_len_1", last_frame_len, 16'd1);
`endif

        // commit mid-STREAM with a same-cycle write of tap 3, plus a gap
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        step();
        chk("gap_enable", enable, 1'b0);
        chk("gap_hold", input_data, 16'd2);
        chk("gap_busy", busy, 1'b1);
        send(16'd3, 1'b0);
        coeff_wr_en = 1'b1; coeff_wr_addr = 3'd3; coeff_wr_data = 16'hFFFF;
        coeff_commit = 1'b1;
        send(16'd4, 1'b0);
        coeff_wr_en = 1'b0; coeff_commit = 1'b0;
        chk("coeff_mid_stream", coeff, c_a);
        coeff_commit = 1'b1;
        send(16'd5, 1'b0);
        coeff_commit = 1'b0;
        send(16'd6, 1'b1);
        flush(c_a);
        // flush() stepped into the swap cycle; swap lands on that edge
        chk("deferred_swap", coeff, c_b);
        chk("ready_after_deferred", s_ready, 1'b1);
`ifdef CONVOL_FEEDER_STATS_EN
        chk("frame_count_3", frame_count, 16'd3);
        chk("frame_len_6", last_frame_len, 16'd6);
`endif

        // reset in the middle of a flush
        send(16'd9, 1'b0);
        send(16'd8, 1'b1);
        for (int j = 0; j < 3; j++) step();
        chk("in_flush", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_enable", enable, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_coeff", coeff, '0);
        chk("async_ready", s_ready, 1'b0);
        chk("async_done", frame_done, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_done", frame_done, 1'b0);
        chk("post_rst_ready", s_ready, 1'b1);
        send(16'h0123, 1'b1);
        flush('0);
`ifdef CONVOL_FEEDER_STATS_EN
        chk("count_after_rst", frame_count, 16'd1);
`endif

        // out-of-range shadow address on a 5-tap instance is ignored
        b_wr_en = 1'b1; b_wr_addr = 3'd6; b_wr_data = 16'hAAAA;
        step();
        b_wr_addr = 3'd4; b_wr_data = 16'h1234;
        step();
        b_wr_en = 1'b0; b_commit = 1'b1;
        step();
        b_commit = 1'b0;
        chk("b_stall", b_ready, 1'b0);
        step();
        chk("b_coeff", b_coeff, {16'h1234, 64'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
